// File: rtl/axil_mmio_bridge.sv
// axil_mmio_bridge: single-outstanding CPU load/store to AXI4-Lite master bridge.
// Define AXIL_TIMEOUT_EN to abandon transactions stuck for TIMEOUT_CYCLES cycles.
module axil_mmio_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);
    typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t                state, state_n;
    logic [ADDR_W-1:0]     addr, addr_n;
    logic [DATA_W-1:0]     wdata, wdata_n, resp_rdata_n;
    logic [DATA_W/8-1:0]   wstrb, wstrb_n;
    logic                  awvalid_n, wvalid_n, arvalid_n, aw_done, aw_done_n, w_done, w_done_n;
    logic                  resp_valid_n, resp_err_n;
    logic                  aw_hs, w_hs;

    assign aw_hs     = m_awvalid & m_awready;
    assign w_hs      = m_wvalid & m_wready;
    assign m_awaddr  = addr;
    assign m_araddr  = addr;
    assign m_wdata   = wdata;
    assign m_wstrb   = wstrb;
    assign m_awprot  = 3'b000;
    assign m_arprot  = 3'b000;
    assign m_bready  = state == WR_RESP;
    assign m_rready  = state == RD_DATA;
    // Holding off during the response pulse keeps the next request one cycle behind it.
    assign req_ready = rst && state == IDLE && !resp_valid;

`ifdef AXIL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt, cnt_n;
`endif

    always_comb begin
        state_n      = state;
        addr_n       = addr;
        wdata_n      = wdata;
        wstrb_n      = wstrb;
        awvalid_n    = m_awvalid;
        wvalid_n     = m_wvalid;
        arvalid_n    = m_arvalid;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        resp_valid_n = 1'b0;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;
        case (state)
            IDLE: if (req_valid && req_ready) begin
                addr_n    = req_addr;
                wdata_n   = req_wdata;
                wstrb_n   = req_wstrb;
                awvalid_n = req_we;
                wvalid_n  = req_we;
                arvalid_n = !req_we;
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
                state_n   = req_we ? WRITE : RD_ADDR;
            end
            WRITE: begin
                if (aw_hs) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (w_hs) begin
                    wvalid_n = 1'b0;
                    w_done_n = 1'b1;
                end
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
            end
            WR_RESP: if (m_bvalid) begin
                resp_valid_n = 1'b1;
                resp_rdata_n = '0;
                resp_err_n   = |m_bresp;
                state_n      = IDLE;
            end
            RD_ADDR: if (m_arready) begin
                arvalid_n = 1'b0;
                state_n   = RD_DATA;
            end
            RD_DATA: if (m_rvalid) begin
                resp_valid_n = 1'b1;
                resp_rdata_n = m_rdata;
                resp_err_n   = |m_rresp;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
`ifdef AXIL_TIMEOUT_EN
        cnt_n = (state_n == IDLE || state_n != state) ? '0 : cnt + 1'b1;
        // Fires one cycle early so the abort is visible in the TIMEOUT_CYCLES-th cycle.
        if (state != IDLE && cnt == CW'(TIMEOUT_CYCLES - 2)) begin
            state_n      = IDLE;
            awvalid_n    = 1'b0;
            wvalid_n     = 1'b0;
            arvalid_n    = 1'b0;
            resp_valid_n = 1'b1;
            resp_rdata_n = '0;
            resp_err_n   = 1'b1;
            cnt_n        = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr       <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            m_awvalid  <= 1'b0;
            m_wvalid   <= 1'b0;
            m_arvalid  <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            wdata      <= wdata_n;
            wstrb      <= wstrb_n;
            m_awvalid  <= awvalid_n;
            m_wvalid   <= wvalid_n;
            m_arvalid  <= arvalid_n;
            aw_done    <= aw_done_n;
            w_done     <= w_done_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
        end
    end

`ifdef AXIL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt_n;
    end
`endif
endmodule
